// File: rtl/cfg_serial_rx.sv
// -----------------------------------------------------------------------------
// cfg_serial_rx
//   Serial configuration receiver and power-up sequencer. The FPGA serial link
//   (i_sclk / i_sdin) is oversampled in the i_clk domain. 12-bit frames are
//   assembled MSB first and validated. Gain codes are then applied, and the
//   amplifier and VCO resets are released in a fixed, evenly spaced order.
//
// Ports
//   i_clk        main clock, all logic on the rising edge
//   i_rst        asynchronous, active-high reset
//   i_sclk       serial clock from the FPGA (asynchronous)
//   i_sdin       serial data from the FPGA (asynchronous)
//   o_ready      configuration applied and release sequence complete
//   o_resetb1    active-low reset, amplifier 1
//   o_gainA1     amplifier 1 gain code
//   o_resetb2    active-low reset, amplifier 2
//   o_gainA2     amplifier 2 gain code
//   o_resetbvco  active-low reset, VCO
//   o_frame_err  one-cycle pulse for every rejected frame
// -----------------------------------------------------------------------------
module cfg_serial_rx #(
    parameter int STEP_CYCLES = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_sdin,
    output logic       o_ready,
    output logic       o_resetb1,
    output logic [1:0] o_gainA1,
    output logic       o_resetb2,
    output logic [2:0] o_gainA2,
    output logic       o_resetbvco,
    output logic       o_frame_err
);

    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_CFG = 3'd0,
        REL1     = 3'd1,
        REL2     = 3'd2,
        RELVCO   = 3'd3,
        READY    = 3'd4
    } state_t;

    // Even parity over the whole frame: XOR of all 12 bits must be zero.
    function automatic logic parity_is_even(input logic [11:0] frame);
        return ((^frame) == 1'b0);
    endfunction

    // Sync nibble, reserved bit and parity must all be correct.
    function automatic logic frame_is_valid(input logic [11:0] frame);
        return (frame[11:8] == 4'hA) && (frame[1] == 1'b0) && parity_is_even(frame);
    endfunction

    logic         sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic         sdin_meta_r, sdin_sync_r;
    logic         sclk_rise_s;
    logic [11:0]  shift_r;
    logic [3:0]   bit_cnt_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic         frame_done_r;
    logic         frame_ok_s;
    logic         step_last_s;

    state_t       state_r, state_s;
    logic [STEP_W-1:0] step_cnt_r, step_cnt_s;
    logic         ready_r, ready_s;
    logic         resetb1_r, resetb1_s;
    logic         resetb2_r, resetb2_s;
    logic         resetbvco_r, resetbvco_s;
    logic [1:0]   gain1_r, gain1_s;
    logic [2:0]   gain2_r, gain2_s;
    logic         vco_en_r, vco_en_s;
    logic         err_r, err_s;

    // Two-flop synchronizers for sclk/sdin plus the sclk edge-detect flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            sdin_meta_r <= 1'b0;
            sdin_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= i_sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            sdin_meta_r <= i_sdin;
            sdin_sync_r <= sdin_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
    assign frame_ok_s  = frame_is_valid(shift_r);
    assign step_last_s = (step_cnt_r == STEP_LAST);

    // Frame assembly: shift on each sclk rise, count bits, drop stale partial frames.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_r      <= 12'h000;
            bit_cnt_r    <= 4'd0;
            idle_cnt_r   <= {IDLE_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (sclk_rise_s) begin
                // An edge always wins over a simultaneous timeout.
                shift_r    <= {shift_r[10:0], sdin_sync_r};
                idle_cnt_r <= {IDLE_W{1'b0}};
                if (bit_cnt_r == 4'd11) begin
                    bit_cnt_r    <= 4'd0;
                    frame_done_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (idle_cnt_r == IDLE_LAST) begin
                    bit_cnt_r  <= 4'd0;
                    idle_cnt_r <= {IDLE_W{1'b0}};
                end else begin
                    idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                end
            end else begin
                idle_cnt_r <= {IDLE_W{1'b0}};
            end
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        step_cnt_s  = step_cnt_r;
        ready_s     = ready_r;
        resetb1_s   = resetb1_r;
        resetb2_s   = resetb2_r;
        resetbvco_s = resetbvco_r;
        gain1_s     = gain1_r;
        gain2_s     = gain2_r;
        vco_en_s    = vco_en_r;
        err_s       = 1'b0;

        // Rejected frames are flagged regardless of sequencer state.
        if (frame_done_r && !frame_ok_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end

        case (state_r)
            WAIT_CFG: begin
                if (frame_done_r && frame_ok_s) begin
                    gain1_s    = shift_r[7:6];
                    gain2_s    = shift_r[5:3];
                    vco_en_s   = shift_r[2];
                    resetb1_s  = 1'b1;
                    step_cnt_s = {STEP_W{1'b0}};
                    state_s    = REL1;
                end else begin
                    state_s = WAIT_CFG;
                end
            end
            REL1: begin
                if (step_last_s) begin
                    resetb2_s  = 1'b1;
                    step_cnt_s = {STEP_W{1'b0}};
                    state_s    = REL2;
                end else begin
                    step_cnt_s = step_cnt_r + STEP_W'(1);
                end
            end
            REL2: begin
                if (step_last_s) begin
                    step_cnt_s = {STEP_W{1'b0}};
                    if (vco_en_r) begin
                        resetbvco_s = 1'b1;
                        state_s     = RELVCO;
                    end else begin
                        ready_s = 1'b1;
                        state_s = READY;
                    end
                end else begin
                    step_cnt_s = step_cnt_r + STEP_W'(1);
                end
            end
            RELVCO: begin
                if (step_last_s) begin
                    ready_s    = 1'b1;
                    step_cnt_s = {STEP_W{1'b0}};
                    state_s    = READY;
                end else begin
                    step_cnt_s = step_cnt_r + STEP_W'(1);
                end
            end
            READY: begin
                // Only the gains follow later frames; resets and ready are sticky.
                if (frame_done_r && frame_ok_s) begin
                    gain1_s = shift_r[7:6];
                    gain2_s = shift_r[5:3];
                end else begin
                    state_s = READY;
                end
            end
            default: begin
                state_s    = WAIT_CFG;
                step_cnt_s = {STEP_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= WAIT_CFG;
            step_cnt_r  <= {STEP_W{1'b0}};
            ready_r     <= 1'b0;
            resetb1_r   <= 1'b0;
            resetb2_r   <= 1'b0;
            resetbvco_r <= 1'b0;
            gain1_r     <= 2'd0;
            gain2_r     <= 3'd0;
            vco_en_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            step_cnt_r  <= step_cnt_s;
            ready_r     <= ready_s;
            resetb1_r   <= resetb1_s;
            resetb2_r   <= resetb2_s;
            resetbvco_r <= resetbvco_s;
            gain1_r     <= gain1_s;
            gain2_r     <= gain2_s;
            vco_en_r    <= vco_en_s;
            err_r       <= err_s;
        end
    end

    assign o_ready     = ready_r;
    assign o_resetb1   = resetb1_r;
    assign o_resetb2   = resetb2_r;
    assign o_resetbvco = resetbvco_r;
    assign o_gainA1    = gain1_r;
    assign o_gainA2    = gain2_r;
    assign o_frame_err = err_r;

endmodule

// File: tb/tb_cfg_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_cfg_serial_rx
//   Self-checking bench for cfg_serial_rx. A timeline model predicts every
//   output on every cycle from the frames the bench sends; a vector table and
//   a few hand-written sequences add independent constant expectations.
// -----------------------------------------------------------------------------
module tb_cfg_serial_rx;

    localparam int S  = 16;
    localparam int TO = 64;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sclk = 1'b0;
    logic       sdin = 1'b0;
    logic       ready, rb1, rb2, rbvco, ferr;
    logic [1:0] g1;
    logic [2:0] g2;

    cfg_serial_rx #(.STEP_CYCLES(S), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_sdin(sdin),
        .o_ready(ready), .o_resetb1(rb1), .o_gainA1(g1), .o_resetb2(rb2),
        .o_gainA2(g2), .o_resetbvco(rbvco), .o_frame_err(ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- timeline reference model ----------------
    int         m_t1;        // cycle at which resetb1 becomes visible, -1 = none
    logic       m_vco;
    logic [1:0] m_g1, m_pg1;
    logic [2:0] m_g2, m_pg2;
    int         m_pend_t;    // cycle at which pending gains become visible
    int         m_err_t;     // cycle of the expected error pulse
    int         m_bits;
    int         m_last_rise;
    logic [11:0] m_word;
    bit         mon_en = 1'b0;

    int rt_rb1, rt_rb2, rt_vco, rt_rdy, err_seen;

    function automatic int ready_time();
        return m_t1 + (m_vco ? 3 * S : 2 * S);
    endfunction

    task automatic model_clear();
        m_t1 = -1; m_vco = 1'b0; m_g1 = 2'd0; m_g2 = 3'd0; m_pg1 = 2'd0; m_pg2 = 3'd0;
        m_pend_t = -1; m_err_t = -1; m_bits = 0; m_last_rise = 0; m_word = 12'h000;
    endtask

    // A complete frame whose outputs would appear at cycle t1.
    task automatic model_frame(input logic [11:0] f, input int t1);
        logic ok;
        ok = (f[11:8] == 4'hA) && (f[1] == 1'b0) && ((^f) == 1'b0);
        if (m_pend_t >= 0) begin
            m_g1 = m_pg1; m_g2 = m_pg2; m_pend_t = -1;
        end
        if (!ok) begin
            m_err_t = t1;
        end else if (m_t1 < 0) begin
            m_t1 = t1; m_vco = f[2];
            m_pend_t = t1; m_pg1 = f[7:6]; m_pg2 = f[5:3];
        end else if (t1 - 1 >= ready_time()) begin
            m_pend_t = t1; m_pg1 = f[7:6]; m_pg2 = f[5:3];
        end
    endtask

    // The bench only uses bit gaps far below or far above the idle limit.
    task automatic model_rise(input logic b, input int n);
        if (m_bits > 0 && (n - m_last_rise) > TO + 8) m_bits = 0;
        m_word = {m_word[10:0], b};
        m_bits++;
        m_last_rise = n;
        if (m_bits == 12) begin
            m_bits = 0;
            model_frame(m_word, n + 4);
        end
    endtask

    task automatic monitor();
        logic [1:0] e_g1;
        logic [2:0] e_g2;
        logic       on;
        forever begin
            @(negedge clk);
            if (rst) begin
                rt_rb1 = -1; rt_rb2 = -1; rt_vco = -1; rt_rdy = -1; err_seen = 0;
            end else begin
                if (rb1   && rt_rb1 < 0) rt_rb1 = cyc;
                if (rb2   && rt_rb2 < 0) rt_rb2 = cyc;
                if (rbvco && rt_vco < 0) rt_vco = cyc;
                if (ready && rt_rdy < 0) rt_rdy = cyc;
                if (ferr) err_seen++;
            end
            if (mon_en) begin
                on   = (m_t1 >= 0);
                e_g1 = (m_pend_t >= 0 && cyc >= m_pend_t) ? m_pg1 : m_g1;
                e_g2 = (m_pend_t >= 0 && cyc >= m_pend_t) ? m_pg2 : m_g2;
                check("cycle_model", {ready, rb1, rb2, rbvco, g1, g2, ferr},
                      {on && cyc >= ready_time(), on && cyc >= m_t1, on && cyc >= m_t1 + S,
                       on && m_vco && cyc >= m_t1 + 2 * S, e_g1, e_g2, cyc == m_err_t});
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b, input int lo, input int hi);
        sdin = b;
        tick(lo);
        sclk = 1'b1;
        model_rise(b, cyc);
        tick(hi);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] f, input int lo, input int hi);
        for (int i = 11; i >= 0; i--) send_bit(f[i], lo, hi);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sclk = 1'b0;
        sdin = 1'b0;
        model_clear();
        #1;
        check("reset_async", {ready, rb1, rb2, rbvco, g1, g2, ferr}, 10'd0);
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    typedef struct {
        logic [11:0] frame;
        logic        err;
        logic [1:0]  g1;
        logic [2:0]  g2;
        logic        vco;
        logic        rdy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [11:0] f;
        logic [1:0]  rg1;
        logic [2:0]  rg2;
        int          k;

        model_clear();
        fork
            monitor();
        join_none

        tick(3);
        check("reset_values", {ready, rb1, rb2, rbvco, g1, g2, ferr}, 10'd0);
        rst = 1'b0;
        tick(2);
        mon_en = 1'b1;

        // ---- vector table: each frame applied after a fresh reset ----
        vecs[0] = '{12'hAAC, 1'b0, 2'd2, 3'd5, 1'b1, 1'b1};
        vecs[1] = '{12'hAA9, 1'b0, 2'd2, 3'd5, 1'b0, 1'b1}; // vco_en=0, even parity
        vecs[2] = '{12'hAA8, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // odd parity
        vecs[3] = '{12'hAAD, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // bad parity
        vecs[4] = '{12'h2AC, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // bad sync
        vecs[5] = '{12'hAAE, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // reserved set
        vecs[6] = '{12'hA4D, 1'b0, 2'd1, 3'd1, 1'b1, 1'b1};
        vecs[7] = '{12'hA41, 1'b0, 2'd1, 3'd0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            send_frame(vecs[i].frame, 3, 2);
            tick(4 * S + 10);
            check("vec_err_count", err_seen, {31'd0, vecs[i].err});
            check("vec_outputs", {ready, rb1, rb2, rbvco, g1, g2},
                  {vecs[i].rdy, ~vecs[i].err, ~vecs[i].err, vecs[i].vco, vecs[i].g1, vecs[i].g2});
        end

        // ---- release spacing with vco enabled, then a gain update in READY ----
        do_reset();
        send_frame(12'hAAC, 3, 2);
        tick(4 * S + 10);
        check("seq_rb1_time", rt_rb1, m_last_rise + 4);
        check("seq_rb2_step", rt_rb2 - rt_rb1, S);
        check("seq_vco_step", rt_vco - rt_rb1, 2 * S);
        check("seq_rdy_step", rt_rdy - rt_rb1, 3 * S);
        send_frame(12'hA4D, 3, 2);
        tick(10);
        check("ready_update", {ready, rb1, rb2, rbvco, g1, g2}, {4'b1111, 2'd1, 3'd1});

        // ---- release spacing with vco disabled ----
        do_reset();
        send_frame(12'hAA9, 2, 2);
        tick(4 * S + 10);
        check("novco_rdy_step", rt_rdy - rt_rb1, 2 * S);
        check("novco_vco_low", rt_vco, -1);

        // ---- partial frame then long idle: dropped silently ----
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(i[0], 3, 2);
        tick(TO + 20);
        send_frame(12'hAAC, 3, 2);
        tick(4 * S + 10);
        check("timeout_err", err_seen, 0);
        check("timeout_outs", {ready, rb1, rb2, rbvco, g1, g2}, {4'b1111, 2'd2, 3'd5});
        check("timeout_step", rt_rdy - rt_rb1, 3 * S);

        // ---- short pause inside a frame is not a timeout ----
        do_reset();
        f = 12'hAAC;
        for (int i = 11; i >= 6; i--) send_bit(f[i], 3, 2);
        tick(30);
        for (int i = 5; i >= 0; i--) send_bit(f[i], 3, 2);
        tick(4 * S + 10);
        check("pause_outs", {ready, rb1, rb2, rbvco, g1, g2}, {4'b1111, 2'd2, 3'd5});

        // ---- reset in the middle of the sequence, then restart ----
        do_reset();
        send_frame(12'hAAC, 3, 2);
        k = m_t1 + 20;
        while (cyc < k) tick(1);
        do_reset();
        check("midreset_rb1", rt_rb1, -1);
        send_frame(12'hAAC, 3, 2);
        tick(4 * S + 10);
        check("restart_rb1_time", rt_rb1, m_last_rise + 4);
        check("restart_rdy_step", rt_rdy - rt_rb1, 3 * S);

        // ---- randomized traffic against the timeline model ----
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(1, 11);
                for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), 3, 2);
                tick(TO + 20);
            end
            rg1 = 2'($urandom_range(0, 3));
            rg2 = 3'($urandom_range(0, 7));
            f = {4'hA, rg1, rg2, 1'($urandom_range(0, 1)), 1'b0, 1'b0};
            f[0] = ^f;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 11);
                f[k] = ~f[k];
            end
            for (int i = 11; i >= 0; i--)
                send_bit(f[i], $urandom_range(3, 5), $urandom_range(2, 4));
            tick($urandom_range(0, 20));
        end
        tick(4 * S + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
